// File: rtl/pico_ctrl_sequencer.sv
// Tiny ROM-driven control sequencer: conditional jumps and output-register writes
// gated by synchronized condition inputs, with an IDLE/RUN/HALTED run controller.
module pico_ctrl_sequencer #(
  parameter int          ADDR_W   = 5,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt,
  input  logic              step_en,
  input  logic [7:0]        cond_in,
  input  logic [15:0]       rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [7:0]        reg0_out,
  output logic [7:0]        reg1_out,
  output logic [7:0]        reg2_out,
  output logic [7:0]        reg3_out,
  output logic              wr_strobe,
  output logic [1:0]        wr_sel,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  localparam logic [1:0] ACT_JUMP  = 2'b01;
  localparam logic [1:0] ACT_WRITE = 2'b10;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   pc, pc_nx;
  logic [7:0]          sync1, sync2;
  logic [3:0][7:0]     regs;
  logic                exec, cond_true, do_jump, do_write;

  logic [3:0]          f_cond;
  logic [1:0]          f_act;
  logic [1:0]          f_sel;
  logic [7:0]          f_op;

  assign f_cond = rom_data[15:12];
  assign f_act  = rom_data[11:10];
  assign f_sel  = rom_data[9:8];
  assign f_op   = rom_data[7:0];

  // halt wins over start everywhere; IDLE ignores halt alone
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, HALTED: if (start && !halt) state_nx = RUN;
      RUN:          if (halt)           state_nx = HALTED;
      default:                          state_nx = IDLE;
    endcase
  end

  // only the 2nd synchronizer stage feeds the condition test
  always_comb begin
    exec      = (state == RUN) && step_en && !halt;
    cond_true = (sync2[f_cond[3:1]] == f_cond[0]);
    do_jump   = exec && cond_true && (f_act == ACT_JUMP);
    do_write  = exec && cond_true && (f_act == ACT_WRITE);
    pc_nx     = do_jump ? f_op[ADDR_W-1:0] : pc + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= ADDR_W'(RESET_PC);
      sync1     <= '0;
      sync2     <= '0;
      regs      <= '0;
      wr_strobe <= 1'b0;
      wr_sel    <= '0;
    end else begin
      state     <= state_nx;
      sync1     <= cond_in;
      sync2     <= sync1;
      wr_strobe <= do_write;
      if (exec) pc <= pc_nx;
      if (do_write) begin
        regs[f_sel] <= f_op;
        wr_sel      <= f_sel;
      end
    end
  end

  assign rom_addr = pc;
  assign reg0_out = regs[0];
  assign reg1_out = regs[1];
  assign reg2_out = regs[2];
  assign reg3_out = regs[3];
  assign busy     = (state == RUN);

endmodule

// File: tb/tb_pico_ctrl_sequencer.sv
// Scoreboard bench: a behavioural model predicts the post-edge machine state each
// cycle and queues it; a monitor pops and compares 1ns after every rising edge.
module tb_pico_ctrl_sequencer;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset, start, halt, step_en;
  logic [7:0]    cond_in;
  logic [15:0]   rom_data;
  logic [AW-1:0] rom_addr;
  logic [7:0]    reg0_out, reg1_out, reg2_out, reg3_out;
  logic          wr_strobe, busy;
  logic [1:0]    wr_sel;

  logic [15:0]   rom [32];
  assign rom_data = rom[rom_addr];

  pico_ctrl_sequencer #(.ADDR_W(AW), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .step_en(step_en),
    .cond_in(cond_in), .rom_data(rom_data), .rom_addr(rom_addr),
    .reg0_out(reg0_out), .reg1_out(reg1_out), .reg2_out(reg2_out), .reg3_out(reg3_out),
    .wr_strobe(wr_strobe), .wr_sel(wr_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]      pc;
    logic            busy;
    logic [3:0][7:0] r;
    logic            strobe;
    logic            chk_sel;
    logic [1:0]      sel;
  } exp_t;

  exp_t q[$];
  int tests = 0, fails = 0;

  // reference model: 0=IDLE 1=RUN 2=HALTED
  int              m_st = 0;
  int              m_pc = 0;
  logic [3:0][7:0] m_r = '0;
  logic            m_strobe = 0;
  logic [1:0]      m_sel = 0;
  logic [7:0]      m_s1 = 0, m_s2 = 0;

  always @(posedge clk) begin
    exp_t e;
    logic [15:0] ins;
    bit ok;
    e.chk_sel = 1'b0;
    if (reset) begin
      m_st = 0; m_pc = 0; m_r = '0; m_strobe = 0; m_sel = 0; m_s1 = 0; m_s2 = 0;
      e.chk_sel = 1'b1;
    end else begin
      m_strobe = 0;
      if (m_st == 1 && step_en && !halt) begin
        ins = rom[m_pc];
        ok  = (m_s2[ins[15:13]] == ins[12]);
        if (ok && ins[11:10] == 2'd1) m_pc = ins[7:0] % 32;
        else                          m_pc = (m_pc + 1) % 32;
        if (ok && ins[11:10] == 2'd2) begin
          m_r[ins[9:8]] = ins[7:0];
          m_strobe = 1; m_sel = ins[9:8];
          e.chk_sel = 1'b1;
        end
      end
      if (halt) begin
        if (m_st == 1) m_st = 2;
      end else if (start && m_st != 1) m_st = 1;
      m_s2 = m_s1; m_s1 = cond_in;
    end
    e.pc = m_pc[4:0]; e.busy = (m_st == 1); e.r = m_r;
    e.strobe = m_strobe; e.sel = m_sel;
    q.push_back(e);
  end

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      check("rom_addr", rom_addr, e.pc);
      check("busy", busy, e.busy);
      check("wr_strobe", wr_strobe, e.strobe);
      check("reg0", reg0_out, e.r[0]);
      check("reg1", reg1_out, e.r[1]);
      check("reg2", reg2_out, e.r[2]);
      check("reg3", reg3_out, e.r[3]);
      if (e.chk_sel) check("wr_sel", wr_sel, e.sel);
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1; start = 0; halt = 0; step_en = 0;
    cyc(2);
    reset = 0;
  endtask

  task automatic go();
    start = 1; cyc(1); start = 0;
  endtask

  initial begin
    reset = 1; start = 0; halt = 0; step_en = 0; cond_in = 0;
    for (int i = 0; i < 32; i++) rom[i] = 16'h0000;

    // first write after start, c0 == 0
    rom[0] = 16'h0901; rom[1] = 16'h2401;
    do_reset();
    step_en = 1; go();
    cyc(6);                 // busy-wait at pc 1 while c1 == 0
    cond_in = 8'h02; cyc(4);
    cond_in = 8'h00; cyc(2);

    // jump with upper operand bits set, then wrap 31 -> 0
    rom[0] = 16'h04FF; rom[1] = 16'h0000; rom[31] = 16'h0000;
    do_reset(); step_en = 1; go(); cyc(5);

    // halt and start together in RUN, then resume
    rom[0] = 16'h0000;
    start = 1; halt = 1; cyc(1);
    start = 0; halt = 0; cyc(3);
    go(); cyc(3);

    // step_en gating from pc 4
    do_reset(); step_en = 1; go(); cyc(4);
    step_en = 1; cyc(1); step_en = 0; cyc(2); step_en = 1; cyc(1);

    // reset during a write execution
    for (int i = 0; i < 32; i++) rom[i] = 16'h0A55;
    do_reset(); step_en = 1; go(); cyc(2);
    reset = 1; cyc(1); reset = 0; cyc(2);

    // halt alone in IDLE is ignored, start+halt in IDLE stays IDLE
    halt = 1; cyc(1); start = 1; cyc(1); halt = 0; cyc(1); start = 0; cyc(2);

    // randomized program and control
    for (int i = 0; i < 32; i++) rom[i] = 16'($urandom);
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset   = ($urandom_range(0, 199) == 0);
      start   = ($urandom_range(0, 7) == 0);
      halt    = ($urandom_range(0, 19) == 0);
      step_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) cond_in = 8'($urandom);
      if ($urandom_range(0, 99) == 0) rom[$urandom_range(0, 31)] = 16'($urandom);
      cyc(1);
    end
    reset = 0; start = 0; halt = 0; step_en = 0;
    cyc(3);
    check("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
